// File: rtl/systolic_skew_buffer.sv
// Re-times one matrix row per accept into a diagonal wavefront, lane i delayed i cycles.
// Latency: lane i shows its element for one cycle after edge t+i (lane 0 = 1 cycle).
// No backpressure: rows offered in DRAIN/DONE are dropped and flagged via sticky overflow.
module systolic_skew_buffer #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   in_valid,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  row_in,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  skew_out,
  output logic [MATRIX_SIZE-1:0]                 skew_valid,
  output logic [$clog2(MATRIX_SIZE+1)-1:0]       row_count,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   overflow
);

  localparam int CW = $clog2(MATRIX_SIZE+1);
  localparam logic [CW-1:0] N_CNT = CW'(MATRIX_SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] row_cnt_nxt;
  logic [CW-1:0] drain_cnt, drain_cnt_nxt;
  logic          overflow_nxt;
  logic          accept;

  assign accept = enable && in_valid && (state == IDLE || state == LOAD);
  assign busy   = (state == LOAD) || (state == DRAIN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row_count <= '0;
      drain_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      row_count <= row_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      overflow  <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    row_cnt_nxt   = row_count;
    drain_cnt_nxt = drain_cnt;
    overflow_nxt  = overflow;
    if (!enable) begin
      state_nxt     = IDLE;
      row_cnt_nxt   = '0;
      drain_cnt_nxt = '0;
      overflow_nxt  = 1'b0;
    end else begin
      if (in_valid && (state == DRAIN || state == DONE))
        overflow_nxt = 1'b1;
      case (state)
        IDLE, LOAD: begin
          if (in_valid) begin
            if (row_count != N_CNT)
              row_cnt_nxt = row_count + 1'b1;
            // The Nth accept (the first one when N=1) starts the drain directly.
            if (row_cnt_nxt == N_CNT) begin
              state_nxt     = DRAIN;
              drain_cnt_nxt = '0;
            end else begin
              state_nxt = LOAD;
            end
          end
        end
        DRAIN: begin
          drain_cnt_nxt = drain_cnt + 1'b1;
          if (drain_cnt_nxt == N_CNT)
            state_nxt = DONE;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    logic [i:0]                vld_q;
    logic [i:0][DATA_SIZE-1:0] dat_q;

    // Bubbles carry zero data so the array sees clean padding.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q <= '0;
        dat_q <= '0;
      end else if (!enable) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q[0] <= accept;
        dat_q[0] <= accept ? row_in[i] : '0;
        for (int s = 1; s <= i; s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign skew_out[i]   = dat_q[i];
    assign skew_valid[i] = vld_q[i];
  end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Bench for systolic_skew_buffer: N=2 control table plus N=4 wavefront, lane data via scoreboard.
module tb_systolic_skew_buffer;

  logic              clk = 1'b0;
  logic              reset;
  logic              en2, vld2, en4, vld4;
  logic [1:0][31:0]  row2, so2;
  logic [3:0][31:0]  row4, so4;
  logic [1:0]        sv2, rc2;
  logic [3:0]        sv4;
  logic [2:0]        rc4;
  logic              busy2, done2, ov2, busy4, done4, ov4;

  always #5 clk = ~clk;

  systolic_skew_buffer #(.MATRIX_SIZE(2), .DATA_SIZE(32)) dut2 (
    .clk(clk), .reset(reset), .enable(en2), .in_valid(vld2), .row_in(row2),
    .skew_out(so2), .skew_valid(sv2), .row_count(rc2), .busy(busy2),
    .done(done2), .overflow(ov2));

  systolic_skew_buffer #(.MATRIX_SIZE(4), .DATA_SIZE(32)) dut4 (
    .clk(clk), .reset(reset), .enable(en4), .in_valid(vld4), .row_in(row4),
    .skew_out(so4), .skew_valid(sv4), .row_count(rc4), .busy(busy4),
    .done(done4), .overflow(ov4));

  typedef struct {
    int          dut;
    int          lane;
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        en;
    logic        vld;
    logic [31:0] r0;
    logic [31:0] r1;
    logic        acc;
    int          rc;
    logic        busy;
    logic        done;
    logic        ov;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[17];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  function automatic vec_t mk(input logic en, input logic vld, input logic [31:0] r0,
                              input logic [31:0] r1, input logic acc, input int rc,
                              input logic b, input logic d, input logic o);
    vec_t v;
    v.en = en; v.vld = vld; v.r0 = r0; v.r1 = r1; v.acc = acc;
    v.rc = rc; v.busy = b; v.done = d; v.ov = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, required %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int d, input int ln, input logic [31:0] v, input int due);
    exp_t e;
    e.dut = d; e.lane = ln; e.data = v; e.due = due;
    sb.push_back(e);
  endtask

  task automatic check_lane(input int d, input int ln, input logic v, input logic [31:0] dat);
    int j;
    j = -1;
    for (int k = 0; k < sb.size(); k++)
      if (j < 0 && sb[k].dut == d && sb[k].lane == ln) j = k;
    n_checks++;
    if (v === 1'b1) begin
      if (j < 0) begin
        n_fail++;
        $display("FAIL lane n%0d.%0d (cycle %0d): unexpected valid data %0d, required no valid",
                 d, ln, cyc, dat);
      end else begin
        if (sb[j].due != cyc || sb[j].data !== dat) begin
          n_fail++;
          $display("FAIL lane n%0d.%0d (cycle %0d): got data %0d, required %0d at cycle %0d",
                   d, ln, cyc, dat, sb[j].data, sb[j].due);
        end
        sb.delete(j);
      end
    end else if (v !== 1'b0 || dat !== 32'd0) begin
      n_fail++;
      $display("FAIL lane n%0d.%0d bubble (cycle %0d): got valid %b data %0d, required 0/0",
               d, ln, cyc, v, dat);
    end else if (j >= 0 && sb[j].due <= cyc) begin
      n_fail++;
      $display("FAIL lane n%0d.%0d (cycle %0d): got no valid, required data %0d",
               d, ln, cyc, sb[j].data);
      sb.delete(j);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) check_lane(2, i, sv2[i], so2[i]);
    for (int i = 0; i < 4; i++) check_lane(4, i, sv4[i], so4[i]);
  endtask

  initial begin
    // N=2 stimulus: back-to-back, fetcher cadence with overflow, enable-clear recovery.
    tbl[0]  = mk(1, 1, 1, 2, 1, 1, 1, 0, 0);
    tbl[1]  = mk(1, 1, 3, 4, 1, 2, 1, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 2, 0, 1, 0);
    tbl[4]  = mk(0, 1, 7, 7, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 1, 2, 1, 1, 1, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[9]  = mk(1, 1, 3, 4, 1, 2, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 2, 1, 0, 0);
    tbl[11] = mk(1, 1, 9, 9, 0, 2, 0, 1, 1);
    tbl[12] = mk(1, 1, 9, 9, 0, 2, 0, 1, 1);
    tbl[13] = mk(1, 0, 0, 0, 0, 2, 0, 1, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 1, 5, 6, 1, 1, 1, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);

    reset = 1'b0;
    en2 = 1'b0; vld2 = 1'b0; row2 = '0;
    en4 = 1'b0; vld4 = 1'b0; row4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset skew_out n2", {63'd0, |so2}, 64'd0);
    chk("reset skew_valid n2", {62'd0, sv2}, 64'd0);
    chk("reset row_count n2", {62'd0, rc2}, 64'd0);
    chk("reset busy n2", {63'd0, busy2}, 64'd0);
    chk("reset done n2", {63'd0, done2}, 64'd0);
    chk("reset overflow n2", {63'd0, ov2}, 64'd0);
    chk("reset skew_valid n4", {60'd0, sv4}, 64'd0);
    reset = 1'b1;
    en2 = 1'b1; en4 = 1'b1;

    for (int v = 0; v < 17; v++) begin
      en2     = tbl[v].en;
      vld2    = tbl[v].vld;
      row2[0] = tbl[v].r0;
      row2[1] = tbl[v].r1;
      if (tbl[v].acc) begin
        push(2, 0, tbl[v].r0, cyc + 1);
        push(2, 1, tbl[v].r1, cyc + 2);
      end
      step();
      chk($sformatf("vec%0d row_count", v), {62'd0, rc2}, 64'(tbl[v].rc));
      chk($sformatf("vec%0d busy", v), {63'd0, busy2}, {63'd0, tbl[v].busy});
      chk($sformatf("vec%0d done", v), {63'd0, done2}, {63'd0, tbl[v].done});
      chk($sformatf("vec%0d overflow", v), {63'd0, ov2}, {63'd0, tbl[v].ov});
    end

    // Asynchronous reset mid-LOAD while lane 1 is presenting data.
    vld2 = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async rst skew_out", {63'd0, |so2}, 64'd0);
    chk("async rst skew_valid", {62'd0, sv2}, 64'd0);
    chk("async rst row_count", {62'd0, rc2}, 64'd0);
    chk("async rst busy", {63'd0, busy2}, 64'd0);
    step();
    reset = 1'b1;
    step();
    chk("post rst row_count", {62'd0, rc2}, 64'd0);
    chk("post rst busy", {63'd0, busy2}, 64'd0);
    vld2 = 1'b1; row2[0] = 32'd1; row2[1] = 32'd2;
    push(2, 0, 32'd1, cyc + 1);
    push(2, 1, 32'd2, cyc + 2);
    step();
    chk("post rst accept row_count", {62'd0, rc2}, 64'd1);
    vld2 = 1'b0;
    step();
    en2 = 1'b0;
    step();

    // N=4 back-to-back matrix: wavefront from the scoreboard, done four edges after the last row.
    for (int k = 1; k <= 8; k++) begin
      vld4 = (k <= 4);
      for (int i = 0; i < 4; i++) begin
        row4[i] = (k <= 4) ? 32'(4 * (k - 1) + i + 1) : 32'd0;
        if (k <= 4) push(4, i, row4[i], cyc + 1 + i);
      end
      step();
      chk($sformatf("n4 e%0d row_count", k), {61'd0, rc4}, 64'((k < 4) ? k : 4));
      chk($sformatf("n4 e%0d busy", k), {63'd0, busy4}, {63'd0, (k < 8)});
      chk($sformatf("n4 e%0d done", k), {63'd0, done4}, {63'd0, (k >= 8)});
    end
    vld4 = 1'b0;
    step();
    chk("n4 overflow", {63'd0, ov4}, 64'd0);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_skew_buffer.md
# systolic_skew_buffer

Sits directly downstream of the data fetcher and upstream of the systolic PE array. It accepts one matrix row per valid cycle as a MATRIX_SIZE-wide vector. It re-times the row into the diagonal wavefront the array needs: lane i is delayed i cycles relative to lane 0. It counts the rows of one matrix and reports when the final skewed element has left the block.

## Interface
- MATRIX_SIZE, 2, array dimension N; also the number of rows per matrix.
- DATA_SIZE, 32, element width in bits.

- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low. Asserted when 0.
- enable  in  1  synchronous run enable. Low clears all state on the next edge.
- in_valid  in  1  row_in holds a valid row this cycle.
- row_in  in  DATA_SIZE x MATRIX_SIZE  row elements. Element i feeds lane i.
- skew_out  out  DATA_SIZE x MATRIX_SIZE  skewed elements to the array's row inputs.
- skew_valid  out  MATRIX_SIZE  per-lane valid for skew_out[i].
- row_count  out  $clog2(MATRIX_SIZE+1)  number of rows accepted for the current matrix.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  high in DONE.
- overflow  out  1  sticky. A row was offered while in DRAIN or DONE.

## Operation
- Datapath: lane i is a chain of i+1 registers carrying {valid, data}.
  - A stage holding valid=0 holds data=0, so bubbles are zero-filled.
  - The array relies on zero padding.
- A row is accepted on an edge where in_valid=1 and the state is IDLE or LOAD.
  - Accepted rows enter all lanes' first stages together.
  - A row offered in DRAIN or DONE is dropped. It does not enter the lanes, and overflow sets.
- States:
  - IDLE: row_count=0.
    - Accepting a row moves to LOAD, row_count=1.
    - If N=1, the first accept moves directly to DRAIN.
  - LOAD: each accept increments row_count.
    - The accept that makes row_count=N moves to DRAIN and clears drain_cnt to 0.
  - DRAIN: drain_cnt increments each edge.
    - When drain_cnt reaches N, the state moves to DONE.
    - At that point every lane is empty.
  - DONE: done=1. Holds until enable is low or reset.
- Gaps of any length between valid rows are allowed in IDLE and LOAD. The upstream fetcher presents one row every 4 cycles, and back-to-back rows are also legal.
- enable=0 on an edge, from any state:
  - all lane registers, row_count, drain_cnt and overflow go to 0;
  - the state goes to IDLE;
  - in_valid is ignored that edge.
- reset=0: the same clear, applied immediately and asynchronously. It takes priority over enable.
- Arithmetic:
  - row_count saturates at N.
  - drain_cnt is $clog2(N+1) bits wide.
  - No data arithmetic. Elements pass unmodified.

## Timing
- Reset value of every output is 0: skew_out, skew_valid, row_count, busy, done and overflow.
- Latency: a row accepted at edge t places element i on skew_out[i], with skew_valid[i]=1, for exactly one cycle following edge t+i. Lane 0 latency is 1 cycle; lane N-1 latency is N cycles.
- Last row accepted at edge t:
  - the state is DRAIN from edge t;
  - done rises after edge t+N, the cycle after lane N-1 shows its last element;
  - busy falls on the same edge.
- row_count, busy, done and overflow are registered or state-decoded. None depends combinationally on in_valid.
- Simultaneous events:
  - in_valid on the edge that moves LOAD to DRAIN: the row is accepted, and it is the Nth row.
  - in_valid=1 with enable=0: dropped, and overflow is not set.
- Reset mid-operation: in-flight elements are discarded. No partial wavefront reaches the array after reset releases.

## Test plan
- N=2, back-to-back rows {1,2} at edge 1 and {3,4} at edge 2 -> lane0 shows 1 after e1 and 3 after e2; lane1 shows 2 after e2 and 4 after e3; done=1 after e4; row_count=2.
- N=2, rows {1,2} and {3,4} spaced 4 cycles apart, matching the fetcher cadence -> each element appears for one cycle with its lane offset; zeros with skew_valid=0 between; done 2 cycles after the second accept.
- N=2, a third row {9,9} offered while in DRAIN -> never appears on skew_out; overflow=1 and stays 1 through DONE.
- reset driven low asynchronously mid-LOAD, with lane1 holding 2 -> all outputs 0 before the next edge; after release, IDLE with row_count=0.
- In DONE, enable=0 for one edge, then a new row {5,6} -> done=0, overflow=0, IDLE; the new row is accepted and row_count=1.
- N=4, rows {1,2,3,4} through {13,14,15,16} back-to-back from e1 -> lane3 shows 4 after e4 and 16 after e7; done after e8.
